// File: rtl/complex_div.sv
// Iterative fixed-point complex divider q = (a1 + j*b1) / (a2 + j*b2).
// Two restoring shift-subtract dividers share one denominator.
module complex_div #(
    parameter int DATA_LEN  = 8,
    parameter int FRAC_BITS = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_LEN-1:0]   a1,
    input  logic signed [DATA_LEN-1:0]   b1,
    input  logic signed [DATA_LEN-1:0]   a2,
    input  logic signed [DATA_LEN-1:0]   b2,
    input  logic                         in_vld,
    output logic                         in_rdy,
    output logic signed [2*DATA_LEN-1:0] q_re,
    output logic signed [2*DATA_LEN-1:0] q_im,
    output logic                         div_zero,
    output logic                         out_vld
);

    localparam int W  = 2 * DATA_LEN;
    localparam int N  = W + FRAC_BITS;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, PREP, DIV, FIN} state_t;

    state_t                     state_q;
    logic signed [DATA_LEN-1:0] a1_q, b1_q, a2_q, b2_q;
    logic        [N-1:0]        dre_q, dim_q;
    logic        [W-1:0]        rre_q, rim_q;
    logic        [W:0]          den_q;
    logic                       sre_q, sim_q, zero_q;
    logic        [CW-1:0]       cnt_q;
    logic                       in_rdy_q, out_vld_q, div_zero_q;
    logic signed [W-1:0]        q_re_q, q_im_q;

    logic signed [W:0] a1x, b1x, a2x, b2x;
    logic signed [W:0] num_re, num_im;
    logic        [W:0] mag_re, mag_im, den_w;

    assign a1x = {{(W+1-DATA_LEN){a1_q[DATA_LEN-1]}}, a1_q};
    assign b1x = {{(W+1-DATA_LEN){b1_q[DATA_LEN-1]}}, b1_q};
    assign a2x = {{(W+1-DATA_LEN){a2_q[DATA_LEN-1]}}, a2_q};
    assign b2x = {{(W+1-DATA_LEN){b2_q[DATA_LEN-1]}}, b2_q};

    assign num_re = a1x * a2x + b1x * b2x;
    assign num_im = b1x * a2x - a1x * b2x;
    assign den_w  = a2x * a2x + b2x * b2x;
    assign mag_re = num_re[W] ? -num_re : num_re;
    assign mag_im = num_im[W] ? -num_im : num_im;

    // One restoring step: shift the next dividend bit into the remainder,
    // and shift the resulting quotient bit into the vacated dividend LSB.
    logic [W:0]   tre, tim;
    logic         ge_re, ge_im;
    logic [W-1:0] rre_d, rim_d;
    logic [N-1:0] dre_d, dim_d;

    assign tre   = {rre_q, dre_q[N-1]};
    assign tim   = {rim_q, dim_q[N-1]};
    assign ge_re = (tre >= den_q);
    assign ge_im = (tim >= den_q);
    assign rre_d = ge_re ? W'(tre - den_q) : W'(tre);
    assign rim_d = ge_im ? W'(tim - den_q) : W'(tim);
    assign dre_d = {dre_q[N-2:0], ge_re};
    assign dim_d = {dim_q[N-2:0], ge_im};

    logic signed [W-1:0] res_re, res_im, q_re_d, q_im_d;

    assign res_re = W'(dre_q);
    assign res_im = W'(dim_q);
    assign q_re_d = zero_q ? '0 : (sre_q ? -res_re : res_re);
    assign q_im_d = zero_q ? '0 : (sim_q ? -res_im : res_im);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            a1_q       <= '0;
            b1_q       <= '0;
            a2_q       <= '0;
            b2_q       <= '0;
            dre_q      <= '0;
            dim_q      <= '0;
            rre_q      <= '0;
            rim_q      <= '0;
            den_q      <= '0;
            sre_q      <= 1'b0;
            sim_q      <= 1'b0;
            zero_q     <= 1'b0;
            cnt_q      <= '0;
            in_rdy_q   <= 1'b1;
            out_vld_q  <= 1'b0;
            div_zero_q <= 1'b0;
            q_re_q     <= '0;
            q_im_q     <= '0;
        end else begin
            out_vld_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (in_vld) begin
                        a1_q     <= a1;
                        b1_q     <= b1;
                        a2_q     <= a2;
                        b2_q     <= b2;
                        in_rdy_q <= 1'b0;
                        state_q  <= PREP;
                    end
                end
                PREP: begin
                    dre_q   <= N'(mag_re) << FRAC_BITS;
                    dim_q   <= N'(mag_im) << FRAC_BITS;
                    rre_q   <= '0;
                    rim_q   <= '0;
                    den_q   <= den_w;
                    sre_q   <= num_re[W];
                    sim_q   <= num_im[W];
                    zero_q  <= (den_w == '0);
                    cnt_q   <= CW'(N - 1);
                    state_q <= DIV;
                end
                DIV: begin
                    dre_q <= dre_d;
                    dim_q <= dim_d;
                    rre_q <= rre_d;
                    rim_q <= rim_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        in_rdy_q <= 1'b1;
                        state_q  <= FIN;
                    end
                end
                FIN: begin
                    q_re_q     <= q_re_d;
                    q_im_q     <= q_im_d;
                    div_zero_q <= zero_q;
                    out_vld_q  <= 1'b1;
                    // A waiting operand set is taken here so results stream
                    // back to back with no idle cycle.
                    if (in_vld) begin
                        a1_q     <= a1;
                        b1_q     <= b1;
                        a2_q     <= a2;
                        b2_q     <= b2;
                        in_rdy_q <= 1'b0;
                        state_q  <= PREP;
                    end else begin
                        in_rdy_q <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
            endcase
        end
    end

    assign in_rdy   = in_rdy_q;
    assign out_vld  = out_vld_q;
    assign q_re     = q_re_q;
    assign q_im     = q_im_q;
    assign div_zero = div_zero_q;

endmodule
